// File: rtl/counter_event_fifo_pkg.sv
// Shared definitions for the mode counter and its event FIFO: level codes,
// the layout of an event entry and the FIFO occupancy state encoding.
package counter_event_fifo_pkg;

  localparam logic ALTO = 1'b1;
  localparam logic BAJO = 1'b0;

  localparam int EV_RCO_BIT  = 5;
  localparam int EV_LOAD_BIT = 4;
  localparam int EV_Q_MSB    = 3;
  localparam int EV_W        = EV_RCO_BIT + 1;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'b00,
    FIFO_PARTIAL = 2'b01,
    FIFO_FULL    = 2'b10
  } fifo_state_e;

  function automatic logic [EV_W-1:0] pack_event(input logic rco, input logic load,
                                                 input logic [EV_Q_MSB:0] q);
    logic [EV_W-1:0] e;
    e                   = '0;
    e[EV_RCO_BIT]       = rco;
    e[EV_LOAD_BIT]      = load;
    e[EV_Q_MSB:0]       = q;
    return e;
  endfunction

endpackage

// File: rtl/counter_sync_fifo.sv
// First-word-fall-through FIFO with an EMPTY/PARTIAL/FULL occupancy FSM.
// A write while full is only accepted when the head is popped on the same edge.
module counter_sync_fifo
  import counter_event_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = EV_W,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [LW-1:0] level,
  output logic          drop
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  fifo_state_e   state_reg, state_next;
  logic          push, pop;

  always_comb begin
    pop        = (state_reg != FIFO_EMPTY) && rd;
    push       = wr && ((state_reg != FIFO_FULL) || pop);
    level_next = level_reg;
    state_next = state_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
    case (state_reg)
      FIFO_EMPTY:   if (push) state_next = FIFO_PARTIAL;
      FIFO_PARTIAL: begin
        if (level_next == DEPTH_L)  state_next = FIFO_FULL;
        else if (level_next == '0)  state_next = FIFO_EMPTY;
      end
      FIFO_FULL:    if (pop && !push) state_next = FIFO_PARTIAL;
      default:      state_next = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg  <= FIFO_EMPTY;
      level_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  // Storage is never reset; the output gate hides stale contents.
  always_ff @(posedge clk) begin
    if (push && !srst) mem[wr_ptr_reg] <= din;
  end

  assign valid = (state_reg != FIFO_EMPTY);
  assign dout  = valid ? mem[rd_ptr_reg] : '0;
  assign level = level_reg;
  assign drop  = wr && !push;

endmodule

// File: rtl/counter_event_fifo.sv
// Captures RCO/LOAD events of the mode counter into a FIFO and keeps
// saturating event statistics plus a sticky overflow flag.
module counter_event_fifo
  import counter_event_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     MON_EN,
  input  logic [3:0]               Q,
  input  logic                     RCO,
  input  logic                     LOAD,
  input  logic                     CLR,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [5:0]               OUT_DATA,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic [CNT_W-1:0]         RCO_CNT,
  output logic [CNT_W-1:0]         LOAD_CNT,
  output logic [CNT_W-1:0]         DROP_CNT,
  output logic                     OVF_STICKY
);

  logic             ev;
  logic             drop;
  logic [EV_W-1:0]  ev_data;
  logic [CNT_W-1:0] rco_cnt_reg, load_cnt_reg, drop_cnt_reg;
  logic             sticky_reg;

  assign ev      = MON_EN && (RCO || LOAD);
  assign ev_data = pack_event(RCO, LOAD, Q);

  counter_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (EV_W)
  ) u_fifo (
    .clk   (CLK),
    .srst  (RESET == ALTO),
    .wr    (ev),
    .din   (ev_data),
    .rd    (OUT_READY),
    .valid (OUT_VALID),
    .dout  (OUT_DATA),
    .level (LEVEL),
    .drop  (drop)
  );

  // Clear takes precedence over a coincident event: that event is not counted.
  always_ff @(posedge CLK) begin
    if (RESET == ALTO || CLR == ALTO) begin
      rco_cnt_reg  <= '0;
      load_cnt_reg <= '0;
      drop_cnt_reg <= '0;
      sticky_reg   <= BAJO;
    end else begin
      if (ev && RCO  && rco_cnt_reg  != '1) rco_cnt_reg  <= rco_cnt_reg  + CNT_W'(1);
      if (ev && LOAD && load_cnt_reg != '1) load_cnt_reg <= load_cnt_reg + CNT_W'(1);
      if (drop && drop_cnt_reg != '1)       drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      if (drop)                             sticky_reg   <= ALTO;
    end
  end

  assign RCO_CNT    = rco_cnt_reg;
  assign LOAD_CNT   = load_cnt_reg;
  assign DROP_CNT   = drop_cnt_reg;
  assign OVF_STICKY = sticky_reg;

endmodule

// File: tb/tb_counter_event_fifo.sv
// Bench for counter_event_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model (8-bit and 2-bit counters).
module tb_counter_event_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1, mon_en = 1'b0, rco = 1'b0, load = 1'b0, clr = 1'b0, ready = 1'b0;
  logic [3:0] q_in = '0;

  logic       a_valid, b_valid, a_sticky, b_sticky;
  logic [5:0] a_data, b_data;
  logic [2:0] a_level, b_level;
  logic [7:0] a_rco, a_load, a_drop;
  logic [1:0] b_rco, b_load, b_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_event_fifo #(.DEPTH(DEPTH), .CNT_W(8)) dut_a (
    .CLK(clk), .RESET(reset), .MON_EN(mon_en), .Q(q_in), .RCO(rco), .LOAD(load),
    .CLR(clr), .OUT_VALID(a_valid), .OUT_READY(ready), .OUT_DATA(a_data),
    .LEVEL(a_level), .RCO_CNT(a_rco), .LOAD_CNT(a_load), .DROP_CNT(a_drop),
    .OVF_STICKY(a_sticky));

  counter_event_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
    .CLK(clk), .RESET(reset), .MON_EN(mon_en), .Q(q_in), .RCO(rco), .LOAD(load),
    .CLR(clr), .OUT_VALID(b_valid), .OUT_READY(ready), .OUT_DATA(b_data),
    .LEVEL(b_level), .RCO_CNT(b_rco), .LOAD_CNT(b_load), .DROP_CNT(b_drop),
    .OVF_STICKY(b_sticky));

  // Reference model: unbounded event counts, saturation applied on compare.
  logic [5:0] mq[$];
  int         m_rco, m_load, m_drop;
  bit         m_sticky;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic logic [52:0] exp_vec();
    logic       v;
    logic [5:0] d;
    v = (mq.size() != 0);
    d = v ? mq[0] : 6'd0;
    return {v, d, 3'(mq.size()), 8'(sat(m_rco, 255)), 8'(sat(m_load, 255)),
            8'(sat(m_drop, 255)), m_sticky,
            v, d, 3'(mq.size()), 2'(sat(m_rco, 3)), 2'(sat(m_load, 3)),
            2'(sat(m_drop, 3)), m_sticky};
  endfunction

  function automatic logic [52:0] act_vec();
    return {a_valid, a_data, a_level, a_rco, a_load, a_drop, a_sticky,
            b_valid, b_data, b_level, b_rco, b_load, b_drop, b_sticky};
  endfunction

  task automatic cyc(input logic r, input logic m, input logic [3:0] qv,
                     input logic rc, input logic ld, input logic cl, input logic rd);
    bit pop, evt, drop;
    @(negedge clk);
    reset = r; mon_en = m; q_in = qv; rco = rc; load = ld; clr = cl; ready = rd;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_rco = 0; m_load = 0; m_drop = 0; m_sticky = 0;
    end else begin
      pop  = (mq.size() != 0) && rd;
      evt  = m && (rc || ld);
      drop = evt && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (evt && !drop) mq.push_back({rc, ld, qv});
      if (cl) begin
        m_rco = 0; m_load = 0; m_drop = 0; m_sticky = 0;
      end else begin
        m_rco  += int'(evt && rc);
        m_load += int'(evt && ld);
        m_drop += int'(drop);
        m_sticky |= drop;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rd);
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, rd);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({a_valid, a_data, a_level, a_rco, a_sticky} !== 24'd0) begin
      errors++; $display("FAIL reset_init got=%h want=0", {a_valid, a_data, a_level, a_rco, a_sticky});
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'(i + 1), 1, 0, 0, 0);
    checks++;
    if (act_vec() !== exp_vec() || a_level !== 3'd3) begin
      errors++; $display("FAIL prefill got=%h want=%h", act_vec(), exp_vec());
    end
    cyc(1, 1, 4'h7, 1, 0, 0, 1);
    cyc(1, 1, 4'h7, 1, 0, 0, 1);
    idle(0);
    checks++;
    if ({a_valid, a_data, a_level, a_rco, a_load, a_drop, a_sticky} !== 35'd0 || act_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_mid got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_single_rco();
    cyc(0, 1, 4'h0, 1, 0, 0, 0);
    checks++;
    if (a_valid !== 1'b1 || a_data !== 6'b10_0000 || a_rco !== 8'd1 || a_level !== 3'd1) begin
      errors++; $display("FAIL single_rco got v=%b d=%b rco=%0d lvl=%0d want v=1 d=100000 rco=1 lvl=1",
                         a_valid, a_data, a_rco, a_level);
    end
    idle(1);
    checks++;
    if (act_vec() !== exp_vec() || a_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_fill_drop();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 4'hA, 0, 1, 0, 0);
    checks++;
    if (a_level !== 3'd4 || a_drop !== 8'd2 || a_sticky !== 1'b1 || a_load !== 8'd6) begin
      errors++; $display("FAIL fill_drop got lvl=%0d drop=%0d sticky=%b load=%0d want 4 2 1 6",
                         a_level, a_drop, a_sticky, a_load);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_data !== 6'b01_1010 || a_valid !== 1'b1) begin
        errors++; $display("FAIL drain%0d got v=%b d=%b want v=1 d=011010", i, a_valid, a_data);
      end
      idle(1);
    end
    checks++;
    if (act_vec() !== exp_vec() || a_valid !== 1'b0) begin
      errors++; $display("FAIL drained got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_full_pop_push();
    logic [5:0] last;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'(i), 1, 0, 0, 0);
    cyc(0, 1, 4'h5, 0, 1, 0, 1);
    checks++;
    if (a_level !== 3'd4 || a_drop !== 8'd0 || a_sticky !== 1'b0) begin
      errors++; $display("FAIL full_pop_push got lvl=%0d drop=%0d sticky=%b want 4 0 0",
                         a_level, a_drop, a_sticky);
    end
    last = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL fpp_drain%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      last = a_data;
      idle(1);
    end
    checks++;
    if (last !== 6'b01_0101) begin
      errors++; $display("FAIL fpp_last got=%b want=010101", last);
    end
  endtask

  task automatic test_both_flags();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 4'hF, 1, 1, 0, 0);
    checks++;
    if (a_data !== 6'b11_1111 || a_level !== 3'd1 || a_rco !== 8'd1 || a_load !== 8'd1) begin
      errors++; $display("FAIL both_flags got d=%b lvl=%0d rco=%0d load=%0d want 111111 1 1 1",
                         a_data, a_level, a_rco, a_load);
    end
  endtask

  task automatic test_saturate_clr();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 4'(i), 1, 0, 0, 0);
    checks++;
    if (b_rco !== 2'd3 || a_rco !== 8'd5 || b_drop !== 2'd1 || b_sticky !== 1'b1) begin
      errors++; $display("FAIL saturate got b_rco=%0d a_rco=%0d b_drop=%0d sticky=%b want 3 5 1 1",
                         b_rco, a_rco, b_drop, b_sticky);
    end
    cyc(0, 1, 4'h9, 1, 0, 1, 0);
    checks++;
    if ({a_rco, a_load, a_drop, a_sticky, b_rco, b_sticky} !== 28'd0 || a_level !== 3'd4) begin
      errors++; $display("FAIL clr got rco=%0d drop=%0d sticky=%b lvl=%0d want 0 0 0 4",
                         a_rco, a_drop, a_sticky, a_level);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_data !== {2'b10, 4'(i)} || act_vec() !== exp_vec()) begin
        errors++; $display("FAIL clr_keep%0d got d=%b want=%b", i, a_data, {2'b10, 4'(i)});
      end
      idle(1);
    end
  endtask

  task automatic test_random();
    logic r, m, rc, ld, cl, rd;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      m  = ($urandom_range(0, 9) != 0);
      rc = $urandom_range(0, 1) == 1;
      ld = ($urandom_range(0, 2) == 0);
      cl = ($urandom_range(0, 39) == 0);
      rd = ($urandom_range(0, 2) == 0);
      cyc(r, m, 4'($urandom_range(0, 15)), rc, ld, cl, rd);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_rco();
    test_fill_drop();
    test_full_pop_push();
    test_both_flags();
    test_saturate_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
